// File: rtl/comptest_pkg.sv
// Shared definitions for the ADC SPI reader.
//   state_e        : reader FSM states
//   DEF_DATA_BITS  : default conversion word width
//   DEF_DIV        : default divider exponent (sclk half-period = 2**(DIV-1) clocks)
package comptest_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2,
        StHold  = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_BITS = 12;
    localparam int unsigned DEF_DIV       = 4;

endpackage

// File: rtl/clk_tick_gen.sv
// Prescaler producing a one-cycle tick every 2**(DIV-1) clocks.
//   clock_i : system clock
//   reset_i : synchronous active-high reset
//   clear_i : holds the prescaler at zero and suppresses tick while high
//   tick_o  : one-cycle pulse at the end of each half-period
module clk_tick_gen
    import comptest_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned H    = 2 ** (DIV - 1);
    localparam int unsigned CntW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(H - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = ~clear_i & (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI reader for a serial ADC: one conversion word per adc_read rising edge.
// Frame: SETUP (cs low, sclk high, one half-period), SHIFT (DATA_BITS sclk
// periods, sdo sampled on each rising sclk), HOLD (cs high, one half-period).
//   clock_i      : system clock
//   reset_i      : synchronous active-high reset
//   adc_read_i   : read request, rising edge starts a frame
//   sdo_i        : serial data from the ADC, MSB first
//   cs_n_o       : chip select, active low
//   sclk_o       : serial clock, idles high
//   data_o       : last completed conversion word
//   data_valid_o : one-cycle pulse when data_o updates
//   busy_o       : high whenever the FSM is not idle
// Build option ADC_SPI_READER_CONTINUOUS_EN: after the first request, frames
// repeat back-to-back (HOLD -> SETUP) and further requests are ignored.
module adc_spi_reader
    import comptest_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned DIV       = DEF_DIV
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 adc_read_i,
    input  logic                 sdo_i,
    output logic                 cs_n_o,
    output logic                 sclk_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 busy_o
);

    localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS);

    state_e               state_q;
    logic                 adc_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic [BitCntW-1:0]   bit_cnt_q;
    logic                 cs_n_q;
    logic                 sclk_q;
    logic                 dv_q;
    logic                 busy_q;

    logic tick;
    logic start;
    logic prescale_clear;

    assign start = adc_read_i & ~adc_q;
    // Holding the prescaler clear in IDLE aligns the first tick to SETUP entry.
    assign prescale_clear = (state_q == StIdle);

    clk_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (prescale_clear),
        .tick_o  (tick)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            adc_q     <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            adc_q <= adc_read_i;
            dv_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StSetup;
                        cs_n_q    <= 1'b0;
                        sclk_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                        sclk_q  <= 1'b0;
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            // Rising sclk: capture the bit the ADC is presenting.
                            sclk_q    <= 1'b1;
                            shift_q   <= {shift_q[DATA_BITS-2:0], sdo_i};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (bit_cnt_q == LastBit) begin
                            // sclk stays high into HOLD instead of falling.
                            state_q <= StHold;
                            cs_n_q  <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        data_q <= shift_q;
                        dv_q   <= 1'b1;
`ifdef ADC_SPI_READER_CONTINUOUS_EN
                        state_q   <= StSetup;
                        cs_n_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
`else
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cs_n_o       = cs_n_q;
    assign sclk_o       = sclk_q;
    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench for adc_spi_reader with DATA_BITS=12, DIV=2 (H=2).
// An ADC model serialises adc_word MSB first, advancing one bit after every
// rising sclk while cs is low; the reader must hand the same word back.
module tb_adc_spi_reader;

    localparam int unsigned DATA_BITS = 12;
    localparam int unsigned DIV       = 2;
    localparam int unsigned H         = 2;
    localparam int          FRAME     = (2 * DATA_BITS + 2) * H;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 adc_read = 1'b0;
    logic                 sdo = 1'b0;
    logic                 cs_n;
    logic                 sclk;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 busy;

    always #5 clock = ~clock;

    adc_spi_reader #(
        .DATA_BITS (DATA_BITS),
        .DIV       (DIV)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .adc_read_i   (adc_read),
        .sdo_i        (sdo),
        .cs_n_o       (cs_n),
        .sclk_o       (sclk),
        .data_o       (data),
        .data_valid_o (data_valid),
        .busy_o       (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_BITS-1:0] adc_word = '0;
    int   nsent       = 0;
    int   rise_cnt    = 0;
    int   dv_cnt      = 0;
    int   busy_cnt    = 0;
    int   cs_hi_cnt   = 0;
    int   cs_sclk_bad = 0;
    logic prev_sclk   = 1'b1;

    // ADC model and protocol monitors, all sampled on the falling clock edge.
    always @(negedge clock) begin
        if (data_valid === 1'b1) dv_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && cs_n === 1'b1) cs_hi_cnt++;
        if (cs_n === 1'b1) begin
            nsent = 0;
            if (sclk !== 1'b1) cs_sclk_bad++;
        end else if (prev_sclk === 1'b0 && sclk === 1'b1) begin
            nsent++;
            rise_cnt++;
        end
        sdo = (nsent < DATA_BITS) ? adc_word[DATA_BITS-1-nsent] : 1'b0;
        prev_sclk = sclk;
    end

    typedef struct {
        logic [DATA_BITS-1:0] word;
        logic [DATA_BITS-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pulse_req();
        @(negedge clock);
        adc_read = 1'b1;
        @(negedge clock);
        adc_read = 1'b0;
    endtask

    // Waits (bounded) until busy drops; leaves the bench on that negedge.
    task automatic wait_not_busy(input string name);
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 4 * FRAME) begin
            @(negedge clock);
            g++;
        end
        check({name, "_timeout"}, int'(g >= 4 * FRAME), 0);
    endtask

    task automatic run_frame(input logic [DATA_BITS-1:0] word,
                             input logic [DATA_BITS-1:0] exp_data, input string name);
        adc_word = word;
        dv_cnt   = 0;
        busy_cnt = 0;
        rise_cnt = 0;
        pulse_req();
        check({name, "_busy_start"}, int'(busy), 1);
        wait_not_busy(name);
        check({name, "_dv_at_end"}, int'(data_valid), 1);
        check({name, "_data"}, int'(data), int'(exp_data));
        repeat (5) @(negedge clock);
        check({name, "_dv_count"}, dv_cnt, 1);
        check({name, "_busy_len"}, busy_cnt, FRAME);
        check({name, "_sclk_rises"}, rise_cnt, DATA_BITS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{word: 12'hA5C, exp_data: 12'hA5C};
        vecs[1] = '{word: 12'h000, exp_data: 12'h000};
        vecs[2] = '{word: 12'hFFF, exp_data: 12'hFFF};
        vecs[3] = '{word: 12'h001, exp_data: 12'h001};
        vecs[4] = '{word: 12'h800, exp_data: 12'h800};
        vecs[5] = '{word: 12'h5A3, exp_data: 12'h5A3};

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_sclk", int'(sclk), 1);
        check("rst_data", int'(data), 0);
        check("rst_dv", int'(data_valid), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

`ifdef ADC_SPI_READER_CONTINUOUS_EN
        begin
            int g;
            adc_word = 12'h6B2;
            pulse_req();
            for (int k = 0; k < 5; k++) begin
                g = 0;
                while (data_valid !== 1'b1 && g < 4 * FRAME) begin
                    @(negedge clock);
                    g++;
                end
                check("cont_dv_seen", int'(data_valid === 1'b1), 1);
                check("cont_data", int'(data), 12'h6B2);
                if (k > 0) begin
                    check("cont_period", g + 1, FRAME);
                    check("cont_cs_high", cs_hi_cnt, H);
                end
                check("cont_busy", int'(busy), 1);
                cs_hi_cnt = 0;
                // A further request mid-stream must not disturb the cadence.
                if (k == 2) adc_read = 1'b1;
                @(negedge clock);
                adc_read = 1'b0;
            end
        end
`else
        foreach (vecs[i]) begin
            run_frame(vecs[i].word, vecs[i].exp_data, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [DATA_BITS-1:0] w;
            w = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
            repeat ($urandom_range(1, 6)) @(negedge clock);
            run_frame(w, w, $sformatf("rand%0d", i));
        end

        // Second request 10 clocks into a frame is dropped.
        adc_word = 12'h3C5;
        dv_cnt   = 0;
        busy_cnt = 0;
        pulse_req();
        repeat (9) @(negedge clock);
        adc_read = 1'b1;
        @(negedge clock);
        adc_read = 1'b0;
        wait_not_busy("ignore");
        repeat (FRAME + 8) @(negedge clock);
        check("ignore_dv_count", dv_cnt, 1);
        check("ignore_busy_len", busy_cnt, FRAME);
        check("ignore_data", int'(data), 12'h3C5);

        // Reset 20 clocks into a frame aborts it.
        adc_word = 12'h5A5;
        dv_cnt   = 0;
        pulse_req();
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_cs_n", int'(cs_n), 1);
        check("midrst_sclk", int'(sclk), 1);
        check("midrst_data", int'(data), 0);
        check("midrst_dv", int'(data_valid), 0);
        check("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (FRAME + 8) @(negedge clock);
        check("midrst_no_dv", dv_cnt, 0);
        run_frame(12'hFFF, 12'hFFF, "after_rst");

        // Request coincident with data_valid starts the next frame at once.
        adc_word = 12'h001;
        dv_cnt   = 0;
        busy_cnt = 0;
        rise_cnt = 0;
        pulse_req();
        wait_not_busy("b2b_first");
        check("b2b_first_dv", int'(data_valid), 1);
        check("b2b_first_data", int'(data), 12'h001);
        adc_word = 12'h800;
        adc_read = 1'b1;
        @(negedge clock);
        adc_read = 1'b0;
        check("b2b_second_busy", int'(busy), 1);
        wait_not_busy("b2b_second");
        check("b2b_second_dv", int'(data_valid), 1);
        check("b2b_second_data", int'(data), 12'h800);
        repeat (5) @(negedge clock);
        check("b2b_dv_count", dv_cnt, 2);
        check("b2b_busy_len", busy_cnt, 2 * FRAME);
        check("b2b_sclk_rises", rise_cnt, 2 * DATA_BITS);
        check("b2b_data_hold", int'(data), 12'h800);
`endif

        check("sclk_high_while_cs_high", cs_sclk_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
